// File: rtl/lane_gather16_serializer_pkg.sv
// Shared types and constants for the 16-lane gather serializer.
package lane_pkg;

  localparam int unsigned NUM_LANES = 16;
  localparam int unsigned SEL_WIDTH = 4;

  typedef logic [SEL_WIDTH-1:0] sel_t;
  typedef logic [NUM_LANES-1:0] mask_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam mask_t ALL_LANES = 16'hFFFF;

endpackage

// File: rtl/lane_gather16_serializer_if.sv
// Frame-in / beat-out bus of lane_gather16_serializer.
// Optional macro LANE_MASK_EN adds the per-frame lane_mask input.
interface lane_gather16_serializer_if
  import lane_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_0,  in_1,  in_2,  in_3;
  logic [DATA_WIDTH-1:0] in_4,  in_5,  in_6,  in_7;
  logic [DATA_WIDTH-1:0] in_8,  in_9,  in_10, in_11;
  logic [DATA_WIDTH-1:0] in_12, in_13, in_14, in_15;
`ifdef LANE_MASK_EN
  mask_t                 lane_mask;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  sel_t                  out_sel;
  logic                  out_last;
  logic                  busy;

  modport slave (
`ifdef LANE_MASK_EN
    input  lane_mask,
`endif
    input  in_valid,
    input  in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
    input  in_8, in_9, in_10, in_11, in_12, in_13, in_14, in_15,
    input  out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last, busy
  );

  modport master (
`ifdef LANE_MASK_EN
    output lane_mask,
`endif
    output in_valid,
    output in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7,
    output in_8, in_9, in_10, in_11, in_12, in_13, in_14, in_15,
    output out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last, busy
  );

endinterface

// File: rtl/lane_gather16_serializer_next.sv
// lane_next_finder: combinational search of a lane mask for the lowest set lane
// and the next set lane above idx; last means idx is the highest set lane.
module lane_next_finder
  import lane_pkg::*;
(
  input  mask_t mask,
  input  sel_t  idx,
  output sel_t  next_idx,
  output sel_t  lowest,
  output logic  has_next,
  output logic  last
);

  logic found_low;

  always_comb begin
    next_idx  = '0;
    lowest    = '0;
    has_next  = 1'b0;
    found_low = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (mask[i] && !found_low) begin
        lowest    = SEL_WIDTH'(i);
        found_low = 1'b1;
      end
      if (mask[i] && (SEL_WIDTH'(i) > idx) && !has_next) begin
        next_idx = SEL_WIDTH'(i);
        has_next = 1'b1;
      end
    end
    last = mask[idx] && !has_next;
  end

endmodule

// File: rtl/lane_gather16_serializer.sv
// Captures a 16-lane frame and emits it one lane per beat with its lane index.
// Optional macro LANE_MASK_EN: per-frame lane_mask selects which lanes are emitted.
module lane_gather16_serializer
  import lane_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  lane_gather16_serializer_if.slave bus
);

  state_t                state;
  logic [DATA_WIDTH-1:0] lane_reg [NUM_LANES];
  logic [DATA_WIDTH-1:0] lanes_in [NUM_LANES];
  sel_t                  idx;
  sel_t                  next_idx;
  sel_t                  first_idx;
  logic                  last_beat;
  logic                  start_emit;
  logic                  busy;
  logic                  beat_done;
  logic                  in_ready;
  logic                  accept;

  assign lanes_in[0]  = bus.in_0;
  assign lanes_in[1]  = bus.in_1;
  assign lanes_in[2]  = bus.in_2;
  assign lanes_in[3]  = bus.in_3;
  assign lanes_in[4]  = bus.in_4;
  assign lanes_in[5]  = bus.in_5;
  assign lanes_in[6]  = bus.in_6;
  assign lanes_in[7]  = bus.in_7;
  assign lanes_in[8]  = bus.in_8;
  assign lanes_in[9]  = bus.in_9;
  assign lanes_in[10] = bus.in_10;
  assign lanes_in[11] = bus.in_11;
  assign lanes_in[12] = bus.in_12;
  assign lanes_in[13] = bus.in_13;
  assign lanes_in[14] = bus.in_14;
  assign lanes_in[15] = bus.in_15;

`ifdef LANE_MASK_EN
  mask_t mask_reg;
  sel_t  unused_cur_lowest;
  logic  unused_cur_has_next;
  sel_t  unused_in_next;
  logic  unused_in_has_next;
  logic  unused_in_last;

  // Held mask drives the stepping; the incoming mask only supplies the first lane.
  lane_next_finder u_cur_finder (
    .mask     (mask_reg),
    .idx      (idx),
    .next_idx (next_idx),
    .lowest   (unused_cur_lowest),
    .has_next (unused_cur_has_next),
    .last     (last_beat)
  );

  lane_next_finder u_in_finder (
    .mask     (bus.lane_mask),
    .idx      ('0),
    .next_idx (unused_in_next),
    .lowest   (first_idx),
    .has_next (unused_in_has_next),
    .last     (unused_in_last)
  );

  assign start_emit = |bus.lane_mask;
`else
  assign next_idx   = idx + 1'b1;
  assign first_idx  = '0;
  assign last_beat  = (idx == SEL_WIDTH'(NUM_LANES - 1));
  assign start_emit = 1'b1;
`endif

  assign busy      = (state == EMIT);
  assign beat_done = busy && bus.out_ready;
  assign in_ready  = !busy || (beat_done && last_beat);
  assign accept    = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = busy;
  assign bus.out_data  = lane_reg[idx];
  assign bus.out_sel   = idx;
  assign bus.out_last  = busy && last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) lane_reg[i] <= '0;
`ifdef LANE_MASK_EN
      mask_reg <= '0;
`endif
    end else if (accept) begin
      // Also taken on the last-beat cycle, so back-to-back frames have no bubble.
      for (int unsigned i = 0; i < NUM_LANES; i++) lane_reg[i] <= lanes_in[i];
`ifdef LANE_MASK_EN
      mask_reg <= bus.lane_mask;
`endif
      idx   <= start_emit ? first_idx : '0;
      state <= start_emit ? EMIT : IDLE;
    end else if (beat_done) begin
      if (last_beat) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx <= next_idx;
      end
    end
  end

endmodule

// File: doc/lane_gather16_serializer.md
Name: lane_gather16_serializer

Overview:
- Reverse direction of the 1-to-16 lane demux used in the transpose-convolution datapath.
- Captures a 16-lane parallel frame, for example one result per PE column.
- Emits the lanes one per beat on a single DATA_WIDTH stream with a valid/ready handshake.
- Each beat carries its lane index, which matches the demux sel encoding, so a downstream demux can re-scatter the data.

Parameters:
- DATA_WIDTH, 16, width of each lane and of the output word.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a frame is present on in_0..in_15.
- in_ready  out  1  the block accepts a frame this cycle.
- in_0 .. in_15  in  DATA_WIDTH each  parallel lane data.
- out_valid  out  1  out_data and out_sel are valid.
- out_ready  in  1  the sink accepts the current beat.
- out_data  out  DATA_WIDTH  current lane word.
- out_sel  out  4  lane index of out_data, 0..15.
- out_last  out  1  current beat is the final beat of the frame.
- busy  out  1  a frame is held, i.e. state is EMIT.

Behaviour:
- Reset (async, active-high): state=IDLE, lane registers=0, idx=0.
  - Outputs during reset: out_valid=0, out_data=0, out_sel=0, out_last=0, busy=0, in_ready=1.
- Registered output path: out_data = lane_reg[idx] and out_sel = idx, both taken from registers. No combinational path from in_* to out_*.
- State machine, two states:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1, all 16 lanes are captured, idx=first emitted lane (0), state→EMIT.
  - EMIT: out_valid=1.
    - A beat completes on out_valid && out_ready; idx advances to the next lane.
    - When the beat with out_last=1 completes, state→IDLE, unless a new frame is accepted in the same cycle (see back-to-back rule).
- Latency: a frame accepted at edge N presents lane 0 at cycle N+1. Sixteen beats take at least 16 cycles.
- out_last=1 iff idx is the final emitted lane (15 without the mask feature).
- Back-to-back frames:
  - in_ready = IDLE || (out_valid && out_ready && out_last). This is a combinational out_ready→in_ready path and is allowed.
  - If a frame is accepted on the last-beat cycle: recapture, idx=0, stay in EMIT. There is no bubble between frames.
- in_valid while in EMIT and not on the last beat: ignored (in_ready=0). Lane registers are stable while a frame is held.
- Stall (out_ready=0): out_data, out_sel and out_last hold; idx does not advance.
- Reset mid-frame: the frame is discarded and the block returns to the reset values immediately.
- idx is 4 bits. There is no wrap past the last lane; the last-beat completion always reloads or idles.

Optional Feature:
- Macro LANE_MASK_EN.
- With the macro defined:
  - Extra input port lane_mask (16 bits), captured with the frame. A bit set to 1 means the lane is emitted.
  - Masked-off lanes are skipped with no bubble; the next idx is the lowest set mask bit above the current idx.
  - The first beat is the lowest set bit. out_last marks the highest set bit.
  - A frame with mask 0 is accepted (in_ready handshake completes), nothing is emitted, and the state stays IDLE.
  - A single-bit mask produces one beat with out_last=1.
- Without the macro: no lane_mask port; all 16 lanes are emitted in order 0..15.

Decomposition:
- Shared package lane_pkg holds:
  - NUM_LANES=16 and SEL_WIDTH=4;
  - state encoding IDLE=1'b0, EMIT=1'b1;
  - ALL_LANES mask constant 16'hFFFF.
- One sub-module is natural: lane_next_finder (combinational). Given a mask and the current idx, it returns the next set lane, the lowest set lane, a has_next flag and a last flag. It is instantiated only under LANE_MASK_EN.

Test Plan:
- Reset:
  - Assert rst mid-frame (after lane 5 is emitted) → next cycle out_valid=0, busy=0, in_ready=1.
  - Deassert rst and send a new frame → lane 0 is emitted first.
- Basic frame:
  - Lanes in_k=16'h1000+k, out_ready=1 → 16 consecutive beats with out_sel=0..15 and out_data=16'h1000..16'h100F.
  - out_last only on sel=15; busy deasserts the following cycle.
- Backpressure:
  - Drop out_ready for 3 cycles at sel=7 → out_data=16'h1007 and sel=7 hold.
  - Emission resumes with sel=8; in_ready stays 0 throughout.
- Back-to-back:
  - Hold in_valid high with a second frame (16'h2000+k) → in_ready pulses on the sel=15 beat only.
  - The next cycle shows sel=0, data=16'h2000, with no idle cycle between frames.
- Ignored input: toggle in_valid and in_* during EMIT → the emitted data is unaffected.
- LANE_MASK_EN:
  - mask=16'h8421 → beats at sel 0, 5, 10, 15 only, with out_last on 15.
  - mask=16'h0000 → handshake completes, no out_valid.
  - mask=16'h0010 → single beat at sel=4 with out_last=1.
